texture_load_controller: RTL and testbench
==========================================

# texture_load_controller

Sequences texture uploads into the texture buffer and keeps uploads from colliding with rasterization. Takes a command stream (one header beat + texel payload) from the command parser, validates the header against buffer capacity, and waits until the rasterizer is idle. It then forwards the payload to the buffer's write stream with a correctly placed `tlast`, and publishes the texture mode plus a ready flag to the read side.

## Interface
- `STREAM_WIDTH`, 16: width of command/payload and buffer write stream; multiple of 16.
- `SIZE`, 15: buffer capacity in bytes, log2.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `s_cmd_axis_tvalid`  in  1  command stream valid.
- `s_cmd_axis_tready`  out  1  command stream ready.
- `s_cmd_axis_tlast`  in  1  last beat of command.
- `s_cmd_axis_tdata`  in  STREAM_WIDTH  header (first beat) or texel payload.
- `m_tex_axis_tvalid`  out  1  to buffer write port.
- `m_tex_axis_tready`  in  1  from buffer.
- `m_tex_axis_tlast`  out  1  final payload beat.
- `m_tex_axis_tdata`  out  STREAM_WIDTH  payload passthrough.
- `rasterBusy`  in  1  rasterizer is reading texels.
- `texMode`  out  4  committed mode, one-hot: 0001 32x32, 0010 64x64, 0100 128x128.
- `texReady`  out  1  buffer holds a complete texture matching `texMode`.
- `loadError`  out  1  last command malformed; sticky until the next accepted header.

## Operation
- Header beat: `tdata[3:0]` is the mode; other bits are ignored.
- Expected beats = texels*16/STREAM_WIDTH (32x32 with 16-bit stream = 1024).
- Mode is valid only if it is one-hot, not 1000, and texels*2 ≤ 2^SIZE.
- States:
  - IDLE: `s_cmd_axis_tready`=1. On a header handshake, latch mode and clear `loadError`.
    - Valid mode → WAIT_RASTER.
    - Invalid mode → DRAIN, with `loadError`=1.
    - Header carrying `tlast` → IDLE, with `loadError`=1.
  - WAIT_RASTER: `s_cmd_axis_tready`=0. Entering this state drops `texReady` to 0. Go to STREAM when `rasterBusy`=0.
  - STREAM: `m_tex_axis_tvalid`=`s_cmd_axis_tvalid`, `s_cmd_axis_tready`=`m_tex_axis_tready`, data passes through combinationally. Count handshakes.
    - `m_tex_axis_tlast`=1 when the count equals expected−1 OR `s_cmd_axis_tlast`=1.
    - Count complete with `s_cmd_axis_tlast`=1 → DONE.
    - Count complete without `s_cmd_axis_tlast` → DRAIN, with `loadError`=1.
    - `s_cmd_axis_tlast` before count complete → IDLE, with `loadError`=1; `texReady` stays 0.
  - DRAIN: `s_cmd_axis_tready`=1, nothing forwarded. Consume beats until `s_cmd_axis_tlast`, then IDLE.
  - DONE: one cycle. `texMode`←latched mode, `texReady`←1, then IDLE.
- The beat counter is log2(max beats)+1 bits wide and resets to 0 on each header.
- A rejected command leaves `texMode` and `texReady` unchanged.

## Timing
- Reset values:
  - `s_cmd_axis_tready`=0 while reset is asserted, 1 in IDLE afterwards.
  - `m_tex_axis_tvalid`=0, `m_tex_axis_tlast`=0, `m_tex_axis_tdata`=0.
  - `texMode`=0001, `texReady`=0, `loadError`=0, state IDLE.
- Payload path has zero latency. Backpressure from `m_tex_axis_tready` propagates in the same cycle.
- Header to first possible forwarded beat: 2 cycles when `rasterBusy`=0.
- `texReady` and `texMode` update on the clock edge after the final beat's handshake.
- Reset asserted mid-STREAM: the FSM aborts to IDLE and `texReady`=0. The buffer is not notified; its write address is realigned by the next `tlast`.

## Configuration
- `TEXTURE_DOUBLE_BUFFER_EN`.
- Defined:
  - Adds output `texBank` (1 bit, reset 0) and an upload bank bit, which is the complement of `texBank`.
  - WAIT_RASTER is skipped: the upload targets the inactive bank while rasterization continues, and `texReady` does not drop.
  - DONE becomes WAIT_SWAP: hold until `rasterBusy`=0, then flip `texBank`, commit `texMode`, set `texReady`=1.
  - A rejected or truncated upload leaves the active bank and `texReady` untouched.
- Undefined: single bank, behaviour as above.

## Structure
- Shared package holds:
  - mode one-hot constants;
  - header field positions;
  - the state enum;
  - a function mapping mode to texel count.
- One sub-module is natural: `texture_beat_counter`, a loadable counter with a terminal-count flag.

## Test plan
- Reset → `texMode`=0001, `texReady`=0, `loadError`=0, `m_tex_axis_tvalid`=0; one cycle after reset release `s_cmd_axis_tready`=1.
- Header 0x0001 + 1024 beats, `m_tex_axis_tready`=1 → 1024 forwarded beats, `m_tex_axis_tlast` on beat 1024; next cycle `texReady`=1, `texMode`=0001.
- Header 0x0002 while `rasterBusy`=1 for 50 cycles → `s_cmd_axis_tready`=0 for those 50 cycles, `texReady`=0; the 4096-beat load then completes.
- Header 0x0003 + 5 beats ending in `tlast` → no forwarded beats, `loadError`=1, previous `texMode` retained.
- Header 0x0001, `s_cmd_axis_tlast` on beat 100 → `m_tex_axis_tlast` on beat 100, `loadError`=1, `texReady`=0.
- Header 0x0001, `m_tex_axis_tready` toggling every cycle → exactly 1024 handshakes, data order preserved, no beat duplicated.

Source files
------------

// File: rtl/texture_load_controller_pkg.sv
// Shared definitions for the texture upload controller: mode encodings,
// header field positions, FSM states and the mode-to-texel-count helper.
package texture_load_controller_pkg;

  // One-hot texture modes carried in the header beat
  localparam logic [3:0] MODE_32  = 4'b0001;
  localparam logic [3:0] MODE_64  = 4'b0010;
  localparam logic [3:0] MODE_128 = 4'b0100;
  localparam logic [3:0] MODE_RSV = 4'b1000;

  // Header field placement
  localparam int HDR_MODE_LSB = 0;
  localparam int HDR_MODE_W   = 4;

  // Largest texture (128x128) bounds the beat counter
  localparam int MAX_TEXELS = 16384;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_RASTER = 3'd1,
    ST_STREAM      = 3'd2,
    ST_DRAIN       = 3'd3,
    ST_DONE        = 3'd4,
    ST_WAIT_SWAP   = 3'd5
  } tlc_state_e;

  // Texel count for a mode; zero flags an unsupported encoding
  function automatic logic [31:0] mode_texels(input logic [3:0] mode);
    logic [31:0] texels;
    case (mode)
      MODE_32:  texels = 32'd1024;
      MODE_64:  texels = 32'd4096;
      MODE_128: texels = 32'd16384;
      default:  texels = 32'd0;
    endcase
    return texels;
  endfunction

endpackage

// File: rtl/texture_beat_counter.sv
// Payload beat counter: cleared on each header, advanced per forwarded
// beat, with a terminal-count flag when the final expected beat is current.
module texture_beat_counter #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Count handshakes; a header clears the count back to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/texture_load_controller.sv
// Texture upload sequencer: validates the header beat, waits for the
// rasterizer to go idle, forwards the payload with a correct tlast and
// commits the texture mode / ready flag to the read side.
// Optional feature macro: TEXTURE_DOUBLE_BUFFER_EN (ping-pong banks, the
// upload targets the inactive bank and the swap waits for raster idle).
module texture_load_controller
  import texture_load_controller_pkg::*;
#(
  parameter int STREAM_WIDTH = 16,
  parameter int SIZE         = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_cmd_axis_tvalid,
  output logic                    s_cmd_axis_tready,
  input  logic                    s_cmd_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_cmd_axis_tdata,
  output logic                    m_tex_axis_tvalid,
  input  logic                    m_tex_axis_tready,
  output logic                    m_tex_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_tex_axis_tdata,
  input  logic                    rasterBusy,
  output logic [3:0]              texMode,
  output logic                    texReady,
`ifdef TEXTURE_DOUBLE_BUFFER_EN
  output logic                    texBank,
`endif
  output logic                    loadError
);

  localparam int          MAX_BEATS = MAX_TEXELS * 16 / STREAM_WIDTH;
  localparam int          CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [31:0] CAPACITY  = 32'd1 << SIZE;

  tlc_state_e       r_state;
  tlc_state_e       w_next;
  logic             r_alive;
  logic [3:0]       r_mode_lat;
  logic [CNT_W-1:0] r_term;
  logic [3:0]       r_tex_mode;
  logic             r_tex_ready;
  logic             r_load_err;

  logic [3:0]       w_hdr_mode;
  logic [31:0]      w_hdr_texels;
  logic             w_hdr_valid;
  logic [CNT_W-1:0] w_hdr_term;

  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_cnt_tc;
  logic             w_latch_hdr;
  logic             w_set_err;
  logic             w_clr_err;
  logic             w_commit;
  logic             w_drop_ready;

`ifdef TEXTURE_DOUBLE_BUFFER_EN
  logic             r_tex_bank;
  logic             w_upload_bank;
  logic             w_swap;
`endif

  // Header decode: mode must map to a texture that fits the buffer (16-bit texels)
  assign w_hdr_mode   = s_cmd_axis_tdata[HDR_MODE_LSB +: HDR_MODE_W];
  assign w_hdr_texels = mode_texels(w_hdr_mode);
  assign w_hdr_valid  = (w_hdr_texels != 32'd0) && ((w_hdr_texels << 1) <= CAPACITY);
  assign w_hdr_term   = CNT_W'((w_hdr_texels * 32'd16) / 32'(STREAM_WIDTH) - 32'd1);

  texture_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .i_terminal (r_term),
    .o_tc       (w_cnt_tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Holds the command port closed for the first cycle out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // Next-state decode, stream steering and status-update strobes
  always_comb begin
    w_next            = r_state;
    s_cmd_axis_tready = 1'b0;
    m_tex_axis_tvalid = 1'b0;
    m_tex_axis_tlast  = 1'b0;
    m_tex_axis_tdata  = '0;
    w_cnt_clr         = 1'b0;
    w_cnt_inc         = 1'b0;
    w_latch_hdr       = 1'b0;
    w_set_err         = 1'b0;
    w_clr_err         = 1'b0;
    w_commit          = 1'b0;
    w_drop_ready      = 1'b0;
`ifdef TEXTURE_DOUBLE_BUFFER_EN
    w_swap            = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        s_cmd_axis_tready = r_alive;
        if (r_alive && s_cmd_axis_tvalid) begin
          w_latch_hdr = 1'b1;
          w_cnt_clr   = 1'b1;
          w_clr_err   = 1'b1;
          if (s_cmd_axis_tlast) begin
            // Header with no payload is malformed
            w_set_err = 1'b1;
            w_next    = ST_IDLE;
          end else if (w_hdr_valid) begin
`ifdef TEXTURE_DOUBLE_BUFFER_EN
            w_next = ST_STREAM;
`else
            w_next       = ST_WAIT_RASTER;
            w_drop_ready = 1'b1;
`endif
          end else begin
            w_set_err = 1'b1;
            w_next    = ST_DRAIN;
          end
        end
      end
      ST_WAIT_RASTER: begin
        if (!rasterBusy) begin
          w_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        m_tex_axis_tvalid = s_cmd_axis_tvalid;
        s_cmd_axis_tready = m_tex_axis_tready;
        m_tex_axis_tdata  = s_cmd_axis_tdata;
        m_tex_axis_tlast  = w_cnt_tc | s_cmd_axis_tlast;
        if (s_cmd_axis_tvalid && m_tex_axis_tready) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_tc) begin
            if (s_cmd_axis_tlast) begin
`ifdef TEXTURE_DOUBLE_BUFFER_EN
              w_next = ST_WAIT_SWAP;
`else
              w_commit = 1'b1;
              w_next   = ST_DONE;
`endif
            end else begin
              // Command longer than the texture: discard the excess
              w_set_err = 1'b1;
              w_next    = ST_DRAIN;
            end
          end else if (s_cmd_axis_tlast) begin
            // Truncated command
            w_set_err = 1'b1;
            w_next    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        s_cmd_axis_tready = 1'b1;
        if (s_cmd_axis_tvalid && s_cmd_axis_tlast) begin
          w_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
`ifdef TEXTURE_DOUBLE_BUFFER_EN
      ST_WAIT_SWAP: begin
        if (!rasterBusy) begin
          w_commit = 1'b1;
          w_swap   = 1'b1;
          w_next   = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Latch the header's mode and final-beat index for the upload in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_lat <= MODE_32;
      r_term     <= '0;
    end else if (w_latch_hdr) begin
      r_mode_lat <= w_hdr_mode;
      r_term     <= w_hdr_term;
    end
  end

  // Published status: sticky error, committed mode and ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tex_mode  <= MODE_32;
      r_tex_ready <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      if (w_set_err) begin
        r_load_err <= 1'b1;
      end else if (w_clr_err) begin
        r_load_err <= 1'b0;
      end
      if (w_commit) begin
        r_tex_mode  <= r_mode_lat;
        r_tex_ready <= 1'b1;
      end else if (w_drop_ready) begin
        r_tex_ready <= 1'b0;
      end
    end
  end

`ifdef TEXTURE_DOUBLE_BUFFER_EN
  // Uploads always land in the bank the rasterizer is not reading
  assign w_upload_bank = ~r_tex_bank;

  // Flip the active bank once the new texture is complete and raster is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tex_bank <= 1'b0;
    end else if (w_swap) begin
      r_tex_bank <= w_upload_bank;
    end
  end

  assign texBank = r_tex_bank;
`endif

  assign texMode   = r_tex_mode;
  assign texReady  = r_tex_ready;
  assign loadError = r_load_err;

endmodule

// File: tb/tb_texture_load_controller.sv
// Directed bench for texture_load_controller (default single-bank build).
module tb_texture_load_controller;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_cmd_axis_tvalid;
  logic        s_cmd_axis_tready;
  logic        s_cmd_axis_tlast;
  logic [15:0] s_cmd_axis_tdata;
  logic        m_tex_axis_tvalid;
  logic        m_tex_axis_tready;
  logic        m_tex_axis_tlast;
  logic [15:0] m_tex_axis_tdata;
  logic        rasterBusy;
  logic [3:0]  texMode;
  logic        texReady;
  logic        loadError;

  int n_chk  = 0;
  int n_pass = 0;

  // Per-command observations
  int fwd, lastpos, nlast, ord_err, first_fwd, busy_lo, busy_rdy;

  always #5 clk = ~clk;

  texture_load_controller #(
    .STREAM_WIDTH (16),
    .SIZE         (15)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_cmd_axis_tvalid (s_cmd_axis_tvalid),
    .s_cmd_axis_tready (s_cmd_axis_tready),
    .s_cmd_axis_tlast  (s_cmd_axis_tlast),
    .s_cmd_axis_tdata  (s_cmd_axis_tdata),
    .m_tex_axis_tvalid (m_tex_axis_tvalid),
    .m_tex_axis_tready (m_tex_axis_tready),
    .m_tex_axis_tlast  (m_tex_axis_tlast),
    .m_tex_axis_tdata  (m_tex_axis_tdata),
    .rasterBusy        (rasterBusy),
    .texMode           (texMode),
    .texReady          (texReady),
    .loadError         (loadError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [31:0] t;
    t = i * 7 + 32'h1234;
    return t[15:0];
  endfunction

  // Present a header beat and hold it until the controller takes it
  task automatic send_hdr(input logic [15:0] hdr, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    s_cmd_axis_tvalid = 1'b1;
    s_cmd_axis_tdata  = hdr;
    s_cmd_axis_tlast  = last;
    #1;
    while (!s_cmd_axis_tready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("hdr_accept", (w < 100) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Push npay payload beats (tlast on beat last_idx, 0 = none) and record
  // what appears on the buffer side; samples sit 1 time unit after negedge.
  task automatic send_pay(input int npay, input int last_idx, input bit tgl, input int busy_cyc);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    fwd = 0; lastpos = 0; nlast = 0; ord_err = 0; first_fwd = -1; busy_lo = 0; busy_rdy = 0;
    while (i < npay && cyc < BUDGET) begin
      @(negedge clk);
      s_cmd_axis_tvalid = 1'b1;
      s_cmd_axis_tdata  = pat(i);
      s_cmd_axis_tlast  = (i + 1 == last_idx);
      m_tex_axis_tready = tgl ? ((cyc % 2) == 1) : 1'b1;
      rasterBusy        = (cyc < busy_cyc);
      #1;
      if (cyc < busy_cyc) begin
        if (!s_cmd_axis_tready) busy_lo++;
        if (texReady) busy_rdy++;
      end
      if (m_tex_axis_tvalid && m_tex_axis_tready) begin
        fwd++;
        if (first_fwd < 0) first_fwd = cyc;
        if (m_tex_axis_tdata !== pat(i)) ord_err++;
        if (m_tex_axis_tlast) begin
          nlast++;
          lastpos = fwd;
        end
      end
      if (s_cmd_axis_tready) i++;
      cyc++;
    end
    check("beats_consumed", i, npay);
    if (npay > 0) @(posedge clk);
    @(negedge clk);
    s_cmd_axis_tvalid = 1'b0;
    s_cmd_axis_tlast  = 1'b0;
    s_cmd_axis_tdata  = 16'h0;
    m_tex_axis_tready = 1'b1;
    rasterBusy        = 1'b0;
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    s_cmd_axis_tvalid = 1'b0;
    s_cmd_axis_tlast  = 1'b0;
    s_cmd_axis_tdata  = 16'hBEEF;
    m_tex_axis_tready = 1'b1;
    rasterBusy        = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_tready", s_cmd_axis_tready, 0);
    check("rst_texMode", texMode, 4'b0001);
    check("rst_texReady", texReady, 0);
    check("rst_loadError", loadError, 0);
    check("rst_m_tvalid", m_tex_axis_tvalid, 0);
    check("rst_m_tlast", m_tex_axis_tlast, 0);
    check("rst_m_tdata", m_tex_axis_tdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_tready", s_cmd_axis_tready, 1);

    // 32x32 load
    send_hdr(16'h0001, 1'b0);
    send_pay(1024, 1024, 1'b0, 0);
    check("b_fwd", fwd, 1024);
    check("b_tlast_pos", lastpos, 1024);
    check("b_tlast_cnt", nlast, 1);
    check("b_order", ord_err, 0);
    check("b_latency", first_fwd + 1, 2);
    check("b_texReady", texReady, 1);
    check("b_texMode", texMode, 4'b0001);
    check("b_loadError", loadError, 0);

    // 64x64 load held off by a busy rasterizer
    send_hdr(16'h0002, 1'b0);
    send_pay(4096, 4096, 1'b0, 50);
    check("c_busy_tready_low", busy_lo, 50);
    check("c_busy_texReady", busy_rdy, 0);
    check("c_first_fwd", first_fwd, 51);
    check("c_fwd", fwd, 4096);
    check("c_tlast_pos", lastpos, 4096);
    check("c_texReady", texReady, 1);
    check("c_texMode", texMode, 4'b0010);

    // Invalid mode 0011 is drained
    send_hdr(16'h0003, 1'b0);
    send_pay(5, 5, 1'b0, 0);
    check("d_fwd", fwd, 0);
    check("d_loadError", loadError, 1);
    check("d_texMode", texMode, 4'b0010);
    check("d_texReady", texReady, 1);

    // Header carrying tlast
    send_hdr(16'h0001, 1'b1);
    send_pay(0, 0, 1'b0, 0);
    check("hl_loadError", loadError, 1);
    check("hl_texReady", texReady, 1);
    check("hl_texMode", texMode, 4'b0010);
    check("hl_tready", s_cmd_axis_tready, 1);

    // Reserved mode 1000 is drained
    send_hdr(16'h0008, 1'b0);
    send_pay(3, 3, 1'b0, 0);
    check("r_fwd", fwd, 0);
    check("r_loadError", loadError, 1);
    check("r_texMode", texMode, 4'b0010);

    // Truncated command: tlast on beat 100
    send_hdr(16'h0001, 1'b0);
    send_pay(100, 100, 1'b0, 0);
    check("e_fwd", fwd, 100);
    check("e_tlast_pos", lastpos, 100);
    check("e_tlast_cnt", nlast, 1);
    check("e_loadError", loadError, 1);
    check("e_texReady", texReady, 0);
    check("e_texMode", texMode, 4'b0010);
    check("e_tready_idle", s_cmd_axis_tready, 1);

    // Reset in the middle of a stream
    send_hdr(16'h0001, 1'b0);
    send_pay(10, 0, 1'b0, 0);
    check("h_fwd", fwd, 10);
    check("h_tready_stream", s_cmd_axis_tready, 1);
    reset = 1'b1;
    #1;
    check("h_texMode", texMode, 4'b0001);
    check("h_texReady", texReady, 0);
    check("h_tready", s_cmd_axis_tready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("h_tready_after", s_cmd_axis_tready, 1);

    // Overlong command: tlast forced on beat 1024, rest drained
    send_hdr(16'h0001, 1'b0);
    send_pay(1030, 1030, 1'b0, 0);
    check("g_fwd", fwd, 1024);
    check("g_tlast_pos", lastpos, 1024);
    check("g_tlast_cnt", nlast, 1);
    check("g_loadError", loadError, 1);
    check("g_texReady", texReady, 0);

    // Toggling backpressure; upper header bits ignored
    send_hdr(16'h7F01, 1'b0);
    send_pay(1024, 1024, 1'b1, 0);
    check("f_fwd", fwd, 1024);
    check("f_order", ord_err, 0);
    check("f_tlast_pos", lastpos, 1024);
    check("f_texReady", texReady, 1);
    check("f_texMode", texMode, 4'b0001);
    check("f_loadError", loadError, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
